// File: rtl/nap_pkg.sv
// nap_pkg: shared state encoding and widths for the nap scheduler
// Exports: state_t (IDLE/NAP/RING/SNOOZE), REMAIN_W, SNZ_W
package nap_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NAP    = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } state_t;
    localparam int REMAIN_W = 12;
    localparam int SNZ_W    = 2;
endpackage

// File: rtl/nap_scheduler_if.sv
// nap_scheduler_if: user-request inputs and sequencer/status outputs of the nap scheduler
// master: drives set_time/nap_sec/go/cancel/snooze/dismiss, observes the status outputs
// slave:  the scheduler side
interface nap_scheduler_if;
    logic                         set_time;
    logic [nap_pkg::REMAIN_W-1:0] nap_sec;
    logic                         go;
    logic                         cancel;
    logic                         snooze;
    logic                         dismiss;
    logic                         alarm_start;
    logic                         alarm_stop;
    logic                         ringing;
    logic [nap_pkg::REMAIN_W-1:0] remain;
    logic [nap_pkg::SNZ_W-1:0]    snooze_cnt;
    logic                         done;
    modport master (
        output set_time, nap_sec, go, cancel, snooze, dismiss,
        input  alarm_start, alarm_stop, ringing, remain, snooze_cnt, done
    );
    modport slave (
        input  set_time, nap_sec, go, cancel, snooze, dismiss,
        output alarm_start, alarm_stop, ringing, remain, snooze_cnt, done
    );
endinterface

// File: rtl/nap_scheduler_tick_gen.sv
// tick_gen: one-cycle tick every TICK_DIV clocks, restartable by clr
// Ports: clock, reset (async, active-high), clr (restart count), tick (out)
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == W'(TICK_DIV - 1);
    always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/nap_scheduler.sv
// nap_scheduler: nap countdown, ring, snooze and time-out control for the alarm sequencer
// Ports: clock, reset (async, active-high), bus (nap_scheduler_if.slave)
module nap_scheduler
    import nap_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int SNOOZE_SEC   = 300,
    parameter int RING_MAX_SEC = 60,
    parameter int MAX_SNOOZE   = 3
) (
    input logic           clock,
    input logic           reset,
    nap_scheduler_if.slave bus
);
    localparam int RING_W = $clog2(RING_MAX_SEC + 1);
    state_t                state_q, state_d;
    logic [REMAIN_W-1:0]   remain_q, remain_d, load_q, load_d;
    logic [SNZ_W-1:0]      snooze_cnt_q, snooze_cnt_d;
    logic [RING_W-1:0]     ring_q, ring_d;
    logic                  alarm_start_q, alarm_start_d, alarm_stop_q, alarm_stop_d;
    logic                  ringing_q, ringing_d, done_q, done_d;
    logic                  clr, tick, can_snz, timeout;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clock(clock), .reset(reset), .clr(clr), .tick(tick));

    assign can_snz = snooze_cnt_q < SNZ_W'(MAX_SNOOZE);
    assign timeout = tick && ring_q == RING_W'(RING_MAX_SEC - 1);

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        load_d       = load_q;
        snooze_cnt_d = snooze_cnt_q;
        ring_d       = ring_q;
        clr          = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.set_time) begin
                    remain_d = bus.nap_sec;
                    load_d   = bus.nap_sec;
                end
                if (bus.go && remain_q != '0) begin
                    state_d      = NAP;
                    clr          = 1'b1;
                    snooze_cnt_d = '0;
                end
            end
            NAP, SNOOZE: begin
                if (bus.cancel) state_d = IDLE;
                else if (tick) begin
                    remain_d = remain_q == '0 ? '0 : remain_q - 1'b1;
                    state_d  = remain_q == REMAIN_W'(1) ? RING : state_q;
                end
            end
            RING: begin
                // a refused snooze falls through so the tick/time-out still counts
                if (bus.cancel || bus.dismiss) state_d = IDLE;
                else if ((bus.snooze || timeout) && can_snz) begin
                    state_d      = SNOOZE;
                    remain_d     = REMAIN_W'(SNOOZE_SEC);
                    snooze_cnt_d = snooze_cnt_q + 1'b1;
                    clr          = 1'b1;
                end
                else if (timeout) state_d = IDLE;
                else if (tick) ring_d = ring_q + 1'b1;
            end
        endcase
        if (state_d == IDLE && state_q != IDLE) begin
            remain_d     = load_q;
            snooze_cnt_d = '0;
            ring_d       = '0;
        end
        if (state_d == RING && state_q != RING) begin
            ring_d = '0;
            clr    = 1'b1;
        end
        alarm_start_d = state_d == RING && state_q != RING;
        alarm_stop_d  = state_d != RING;
        ringing_d     = state_d == RING;
        done_d        = state_q == RING && state_d == IDLE;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q       <= IDLE;
            remain_q      <= '0;
            load_q        <= '0;
            snooze_cnt_q  <= '0;
            ring_q        <= '0;
            alarm_start_q <= 1'b0;
            alarm_stop_q  <= 1'b1;
            ringing_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            load_q        <= load_d;
            snooze_cnt_q  <= snooze_cnt_d;
            ring_q        <= ring_d;
            alarm_start_q <= alarm_start_d;
            alarm_stop_q  <= alarm_stop_d;
            ringing_q     <= ringing_d;
            done_q        <= done_d;
        end

    assign bus.alarm_start = alarm_start_q;
    assign bus.alarm_stop  = alarm_stop_q;
    assign bus.ringing     = ringing_q;
    assign bus.remain      = remain_q;
    assign bus.snooze_cnt  = snooze_cnt_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_nap_scheduler.sv
// tb_nap_scheduler: scoreboard bench for nap_scheduler against a seconds-level reference model
module tb_nap_scheduler;
    localparam int TD = 4, SS = 2, RM = 3, MS = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    nap_scheduler_if bus();
    nap_scheduler #(.TICK_DIV(TD), .SNOOZE_SEC(SS), .RING_MAX_SEC(RM), .MAX_SNOOZE(MS)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    typedef struct {
        bit st, sp, rg, dn;
        int rem, snz;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    // reference model: mode 0 idle, 1 nap, 2 ring, 3 snooze; time measured in clock edges
    int m_mode, m_rem, m_load, m_snz, m_ring, m_clr, m_e;

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_load = 0; m_snz = 0; m_ring = 0; m_clr = 0; m_e = 0;
    endtask

    task automatic go_idle();
        m_mode = 0; m_rem = m_load; m_snz = 0;
    endtask

    task automatic go_snooze();
        m_mode = 3; m_rem = SS; m_snz++; m_clr = m_e;
    endtask

    task automatic compare(string name, exp_t x);
        checks++;
        if (bus.alarm_start !== x.st || bus.alarm_stop !== x.sp || bus.ringing !== x.rg ||
            bus.done !== x.dn || bus.remain !== 12'(x.rem) || bus.snooze_cnt !== 2'(x.snz)) begin
            errors++;
            $display("FAIL %s t=%0t got start=%b stop=%b ring=%b done=%b remain=%0d snz=%0d expected start=%b stop=%b ring=%b done=%b remain=%0d snz=%0d",
                     name, $time, bus.alarm_start, bus.alarm_stop, bus.ringing, bus.done, bus.remain,
                     bus.snooze_cnt, x.st, x.sp, x.rg, x.dn, x.rem, x.snz);
        end
    endtask

    task automatic check_rst(string name);
        exp_t x;
        x.st = 0; x.sp = 1; x.rg = 0; x.dn = 0; x.rem = 0; x.snz = 0;
        compare(name, x);
    endtask

    // one clock: apply inputs, advance the model, queue the expected outputs
    task automatic drive(bit st, int ns, bit g, bit c, bit sn, bit d);
        exp_t x;
        int prev;
        bit tick, dn;
        bus.set_time = st; bus.nap_sec = 12'(ns); bus.go = g;
        bus.cancel = c; bus.snooze = sn; bus.dismiss = d;
        m_e++;
        tick = m_e > m_clr && (m_e - m_clr) % TD == 0;
        prev = m_mode;
        dn = 0;
        if (m_mode == 0) begin
            if (st) begin m_rem = ns; m_load = ns; end
            if (g && m_rem != 0) begin m_mode = 1; m_clr = m_e; end
        end else if (m_mode == 2) begin
            if (c || d) begin go_idle(); dn = 1; end
            else if (sn && m_snz < MS) go_snooze();
            else if (tick) begin
                m_ring++;
                if (m_ring == RM) begin
                    if (m_snz < MS) go_snooze();
                    else begin go_idle(); dn = 1; end
                end
            end
        end else begin
            if (c) go_idle();
            else if (tick) begin
                m_rem--;
                if (m_rem == 0) begin m_mode = 2; m_ring = 0; m_clr = m_e; end
            end
        end
        x.st = m_mode == 2 && prev != 2;
        x.sp = m_mode != 2;
        x.rg = m_mode == 2;
        x.dn = dn;
        x.rem = m_rem;
        x.snz = m_snz;
        q.push_back(x);
        @(negedge clock);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) compare("cycle", q.pop_front());
        end
    end

    initial begin
        bus.set_time = 0; bus.nap_sec = '0; bus.go = 0;
        bus.cancel = 0; bus.snooze = 0; bus.dismiss = 0;
        repeat (2) @(negedge clock);
        check_rst("por");
        reset = 1'b0;
        model_reset();
        drive(0, 0, 1, 0, 0, 0);
        run(3);
        drive(1, 3, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        run(13);
        drive(0, 0, 0, 0, 1, 0);
        run(8);
        drive(0, 0, 0, 0, 1, 0);
        run(8);
        drive(0, 0, 0, 0, 1, 0);
        run(14);
        drive(0, 0, 1, 0, 0, 0);
        run(24);
        run(8);
        drive(0, 0, 0, 1, 1, 0);
        run(2);
        drive(0, 0, 1, 0, 0, 0);
        run(3);
        drive(0, 0, 0, 1, 0, 0);
        run(2);
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0);
        run(12);
        reset = 1'b1;
        #1;
        check_rst("mid_ring_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            drive(r < 5, $urandom_range(0, 4), r >= 5 && r < 15, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end
        run(2);
        @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
